// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS core: load-use stalls, branch flushes, mult/div sequencing.
// Mult/div sequencing is compiled in only when HAZARD_MULDIV_EN is defined.
//
// state      | meaning
// ST_RUN     | normal issue; branch > mult/div start > load-use priority
// ST_MD_WAIT | mult/div in flight, pipeline held until md_done or timeout
module pipeline_hazard_ctrl #(
  parameter int MD_TIMEOUT = 64,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs_id,
  input  logic [4:0]       rt_id,
  input  logic             uses_rs_id,
  input  logic             uses_rt_id,
  input  logic             memread_ex,
  input  logic [4:0]       dest_ex,
  input  logic             branch_taken_ex,
  input  logic             md_start_ex,
  input  logic             md_done,
  input  logic             cnt_clr,
  output logic             stall_pc,
  output logic             stall_if_id,
  output logic             stall_id_ex,
  output logic             bubble_id_ex,
  output logic             bubble_ex_mem,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             md_go,
  output logic             md_busy,
  output logic             md_timeout,
  output logic [CNT_W-1:0] load_stall_cnt,
  output logic [CNT_W-1:0] md_stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WC_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [WC_W-1:0]  WAIT_LAST = WC_W'(MD_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic {ST_RUN, ST_MD_WAIT} state_e;

  state_e           state_q, state_d;
  logic [WC_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic             md_timeout_q, md_timeout_d;
  logic [CNT_W-1:0] load_cnt_q, load_cnt_d;
  logic [CNT_W-1:0] md_cnt_q, md_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;
  logic             lu, md_start_en;
  logic             inc_load, inc_md, inc_flush;

`ifdef HAZARD_MULDIV_EN
  assign md_start_en = md_start_ex;
`else
  // Without the mul/div block the FSM can never leave ST_RUN.
  logic md_start_unused;
  assign md_start_unused = md_start_ex;
  assign md_start_en     = 1'b0;
`endif

  assign lu = memread_ex && (dest_ex != 5'd0) &&
              ((uses_rs_id && (dest_ex == rs_id)) || (uses_rt_id && (dest_ex == rt_id)));

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                input logic inc, input logic clr);
    if (clr) return '0;
    if (inc && (c != CNT_MAX)) return c + 1'b1;
    return c;
  endfunction

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    md_timeout_d  = md_timeout_q;
    stall_pc      = 1'b0;
    stall_if_id   = 1'b0;
    stall_id_ex   = 1'b0;
    bubble_id_ex  = 1'b0;
    bubble_ex_mem = 1'b0;
    flush_if_id   = 1'b0;
    flush_id_ex   = 1'b0;
    md_go         = 1'b0;
    md_busy       = 1'b0;
    inc_load      = 1'b0;
    inc_md        = 1'b0;
    inc_flush     = 1'b0;
    if (rst) begin
      case (state_q)
        ST_RUN: begin
          if (branch_taken_ex) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            inc_flush   = 1'b1;
          end else if (md_start_en) begin
            md_go         = 1'b1;
            stall_pc      = 1'b1;
            stall_if_id   = 1'b1;
            stall_id_ex   = 1'b1;
            bubble_ex_mem = 1'b1;
            inc_md        = 1'b1;
            state_d       = ST_MD_WAIT;
            wait_cnt_d    = '0;
          end else if (lu) begin
            stall_pc     = 1'b1;
            stall_if_id  = 1'b1;
            bubble_id_ex = 1'b1;
            inc_load     = 1'b1;
          end
        end
        ST_MD_WAIT: begin
          md_busy = 1'b1;
          if (md_done) begin
            state_d = ST_RUN;
          end else if (wait_cnt_q == WAIT_LAST) begin
            state_d      = ST_RUN;
            md_timeout_d = 1'b1;
          end else begin
            stall_pc      = 1'b1;
            stall_if_id   = 1'b1;
            stall_id_ex   = 1'b1;
            bubble_ex_mem = 1'b1;
            inc_md        = 1'b1;
            wait_cnt_d    = wait_cnt_q + 1'b1;
          end
        end
        default: state_d = ST_RUN;
      endcase
    end
    load_cnt_d  = cnt_next(load_cnt_q, inc_load, cnt_clr);
    md_cnt_d    = cnt_next(md_cnt_q, inc_md, cnt_clr);
    flush_cnt_d = cnt_next(flush_cnt_q, inc_flush, cnt_clr);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_RUN;
      wait_cnt_q   <= '0;
      md_timeout_q <= 1'b0;
      load_cnt_q   <= '0;
      md_cnt_q     <= '0;
      flush_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      md_timeout_q <= md_timeout_d;
      load_cnt_q   <= load_cnt_d;
      md_cnt_q     <= md_cnt_d;
      flush_cnt_q  <= flush_cnt_d;
    end
  end

  assign md_timeout     = md_timeout_q;
  assign load_stall_cnt = load_cnt_q;
  assign md_stall_cnt   = md_cnt_q;
  assign flush_cnt      = flush_cnt_q;

endmodule
